// File: rtl/nibble_add_sched.sv
// Round-robin scheduler that runs two requesters' WIDTH-bit adds through one shared
// 4-bit adder slice, LSB nibble first, with the carry chained between nibbles.
module nibble_add_sched #(
  parameter int WIDTH   = 16,
  parameter int ADD_LAT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req0_cin,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic             req1_cin,
  output logic [3:0]       add_a,
  output logic [3:0]       add_b,
  output logic             add_cin,
  input  logic [3:0]       add_sum,
  input  logic             add_cout,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_sum,
  output logic             rsp_cout,
  output logic             busy,
  output logic [1:0]       state_dbg
);

  localparam int NIB = WIDTH / 4;
  localparam int IW  = (NIB > 1) ? $clog2(NIB) : 1;
  localparam int LW  = (ADD_LAT > 1) ? $clog2(ADD_LAT) : 1;

  if ((WIDTH % 4) != 0 || WIDTH < 4) begin : g_bad_width
    $error("nibble_add_sched: WIDTH must be a multiple of 4 and at least 4");
  end
  if (ADD_LAT < 1) begin : g_bad_lat
    $error("nibble_add_sched: ADD_LAT must be at least 1");
  end

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  state_t           state, state_nx;
  logic             rr_ptr;
  logic [WIDTH-1:0] a_q, b_q, sum_q;
  logic             id_q;
  logic             carry;
  logic [IW-1:0]    idx;
  logic [LW-1:0]    wcnt;

  logic             any_valid, grant, accept, nib_done, idx_last;
  logic [WIDTH-1:0] a_sh, b_sh;

  // Valid/ready: a request transfers on a rising edge where reqX_valid and
  // reqX_ready are both high; the response transfers where rsp_valid and rsp_ready are.
  always_comb begin
    any_valid  = req0_valid | req1_valid;
    // On a tie the round-robin pointer picks; otherwise the lone valid requester wins.
    grant      = (req0_valid && req1_valid) ? rr_ptr : req1_valid;
    accept     = (state == IDLE) && any_valid;
    req0_ready = accept && !grant;
    req1_ready = accept && grant;
    nib_done   = (wcnt == LW'(ADD_LAT - 1));
    idx_last   = (idx == IW'(NIB - 1));
    a_sh       = a_q >> {idx, 2'b00};
    b_sh       = b_q >> {idx, 2'b00};
  end

  always_comb begin
    state_nx = state;
    add_a    = 4'd0;
    add_b    = 4'd0;
    add_cin  = 1'b0;
    case (state)
      IDLE: if (accept) state_nx = RUN;
      RUN: begin
        add_a   = a_sh[3:0];
        add_b   = b_sh[3:0];
        add_cin = carry;
        if (nib_done && idx_last) state_nx = DONE;
      end
      DONE: if (rsp_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_ptr    <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      sum_q     <= '0;
      id_q      <= 1'b0;
      carry     <= 1'b0;
      idx       <= '0;
      wcnt      <= '0;
      rsp_valid <= 1'b0;
      rsp_cout  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          a_q   <= grant ? req1_a : req0_a;
          b_q   <= grant ? req1_b : req0_b;
          carry <= grant ? req1_cin : req0_cin;
          id_q  <= grant;
          idx   <= '0;
          wcnt  <= '0;
        end
        RUN: begin
          if (nib_done) begin
            sum_q[{idx, 2'b00} +: 4] <= add_sum;
            carry <= add_cout;
            wcnt  <= '0;
            if (idx_last) begin
              rsp_cout  <= add_cout;
              rsp_valid <= 1'b1;
            end else begin
              idx <= idx + IW'(1);
            end
          end else begin
            wcnt <= wcnt + LW'(1);
          end
        end
        DONE: if (rsp_ready) begin
          rsp_valid <= 1'b0;
          rr_ptr    <= ~id_q;
        end
        default: ;
      endcase
    end
  end

  assign rsp_sum   = sum_q;
  assign rsp_id    = id_q;
  assign busy      = (state != IDLE);
  assign state_dbg = state;

endmodule

// File: tb/tb_nibble_add_sched.sv
// Directed bench for nibble_add_sched: a 16-bit/latency-1 instance and an 8-bit/latency-3
// instance, each fed by an ideal 4-bit adder slice.
module tb_nibble_add_sched;

  logic        clk = 1'b0;
  logic        rst;
  int          vec_cnt = 0;
  int          err_cnt = 0;

  // 16-bit, ADD_LAT=1 instance
  logic        req0_valid, req0_ready, req0_cin, req1_valid, req1_ready, req1_cin;
  logic [15:0] req0_a, req0_b, req1_a, req1_b, rsp_sum;
  logic [3:0]  add_a, add_b, add_sum;
  logic        add_cin, add_cout, rsp_valid, rsp_ready, rsp_id, rsp_cout, busy;
  logic [1:0]  state_dbg;

  // 8-bit, ADD_LAT=3 instance
  logic        s_req0_valid, s_req0_ready, s_req0_cin, s_req1_valid, s_req1_ready, s_req1_cin;
  logic [7:0]  s_req0_a, s_req0_b, s_req1_a, s_req1_b, s_rsp_sum;
  logic [3:0]  s_add_a, s_add_b, s_add_sum;
  logic        s_add_cin, s_add_cout, s_rsp_valid, s_rsp_ready, s_rsp_id, s_rsp_cout, s_busy;
  logic [1:0]  s_state_dbg;

  logic [3:0]  obs_a[4];
  logic        obs_cin[4];
  int          obs_lat;

  always #5 clk = ~clk;

  // Ideal slices
  assign {add_cout, add_sum}     = {1'b0, add_a} + {1'b0, add_b} + {4'd0, add_cin};
  assign {s_add_cout, s_add_sum} = {1'b0, s_add_a} + {1'b0, s_add_b} + {4'd0, s_add_cin};

  nibble_add_sched #(.WIDTH(16), .ADD_LAT(1)) u16 (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_cin(req0_cin),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_cin(req1_cin),
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin), .add_sum(add_sum), .add_cout(add_cout),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_sum(rsp_sum), .rsp_cout(rsp_cout),
    .busy(busy), .state_dbg(state_dbg)
  );

  nibble_add_sched #(.WIDTH(8), .ADD_LAT(3)) u8 (
    .clk(clk), .rst(rst),
    .req0_valid(s_req0_valid), .req0_ready(s_req0_ready), .req0_a(s_req0_a), .req0_b(s_req0_b), .req0_cin(s_req0_cin),
    .req1_valid(s_req1_valid), .req1_ready(s_req1_ready), .req1_a(s_req1_a), .req1_b(s_req1_b), .req1_cin(s_req1_cin),
    .add_a(s_add_a), .add_b(s_add_b), .add_cin(s_add_cin), .add_sum(s_add_sum), .add_cout(s_add_cout),
    .rsp_valid(s_rsp_valid), .rsp_ready(s_rsp_ready), .rsp_id(s_rsp_id), .rsp_sum(s_rsp_sum), .rsp_cout(s_rsp_cout),
    .busy(s_busy), .state_dbg(s_state_dbg)
  );

  // Readys must never be high together while both requesters are valid
  always @(negedge clk) begin
    if (rst && req0_valid && req1_valid) begin
      vec_cnt++;
      if (req0_ready && req1_ready) begin
        err_cnt++;
        $display("FAIL one_ready: got req0_ready=1 req1_ready=1, required at most one high");
      end
    end
  end

  // Waits for the grant to `id`, performs the handshake, then records the per-nibble
  // slice drives and the cycle count until rsp_valid. Returns at a negedge.
  task automatic run16(input logic id);
    int t;
    t = 0;
    #1;
    while (((id == 1'b0) ? req0_ready : req1_ready) !== 1'b1 && t < 20) begin
      @(negedge clk); #1; t++;
    end
    vec_cnt++;
    if (t >= 20) begin
      err_cnt++;
      $display("FAIL accept_timeout: id=%0d got no ready, required ready within 20 cycles", id);
    end
    @(posedge clk);
    @(negedge clk);
    if (id == 1'b0) req0_valid = 1'b0; else req1_valid = 1'b0;
    obs_lat = 0;
    while (rsp_valid !== 1'b1 && obs_lat < 50) begin
      if (obs_lat < 4) begin
        obs_a[obs_lat]   = add_a;
        obs_cin[obs_lat] = add_cin;
      end
      obs_lat++;
      @(negedge clk);
    end
  endtask

  task automatic consume16();
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    vec_cnt++; if (rsp_valid !== 1'b0) begin err_cnt++; $display("FAIL rst_rsp_valid: got %0b required 0", rsp_valid); end
    vec_cnt++; if (busy !== 1'b0) begin err_cnt++; $display("FAIL rst_busy: got %0b required 0", busy); end
    vec_cnt++; if (rsp_sum !== 16'h0) begin err_cnt++; $display("FAIL rst_rsp_sum: got %h required 0000", rsp_sum); end
    vec_cnt++; if ({rsp_id, rsp_cout} !== 2'b00) begin err_cnt++; $display("FAIL rst_id_cout: got %b required 00", {rsp_id, rsp_cout}); end
    vec_cnt++; if ({add_a, add_b, add_cin} !== 9'd0) begin err_cnt++; $display("FAIL rst_slice: got %h required 000", {add_a, add_b, add_cin}); end
    vec_cnt++; if ({req0_ready, req1_ready} !== 2'b00) begin err_cnt++; $display("FAIL rst_readys: got %b required 00", {req0_ready, req1_ready}); end
    rst = 1'b1;
    @(negedge clk);
    vec_cnt++; if ({req0_ready, req1_ready, busy} !== 3'b000) begin err_cnt++; $display("FAIL idle_no_req: got %b required 000", {req0_ready, req1_ready, busy}); end
  endtask

  task automatic test_single();
    logic [3:0] exp_a[4];
    exp_a = '{4'h4, 4'h3, 4'h2, 4'h1};
    req0_a = 16'h1234; req0_b = 16'h0FF1; req0_cin = 1'b0; req0_valid = 1'b1;
    run16(1'b0);
    vec_cnt++; if (obs_lat !== 4) begin err_cnt++; $display("FAIL single_latency: got %0d required 4", obs_lat); end
    for (int i = 0; i < 4; i++) begin
      vec_cnt++;
      if (obs_a[i] !== exp_a[i]) begin err_cnt++; $display("FAIL single_add_a[%0d]: got %h required %h", i, obs_a[i], exp_a[i]); end
    end
    vec_cnt++; if (rsp_sum !== 16'h2225) begin err_cnt++; $display("FAIL single_sum: got %h required 2225", rsp_sum); end
    vec_cnt++; if ({rsp_cout, rsp_id} !== 2'b00) begin err_cnt++; $display("FAIL single_cout_id: got %b required 00", {rsp_cout, rsp_id}); end
    vec_cnt++; if (busy !== 1'b1) begin err_cnt++; $display("FAIL single_busy: got %b required 1", busy); end
    consume16();
    vec_cnt++; if ({rsp_valid, busy} !== 2'b00) begin err_cnt++; $display("FAIL single_release: got %b required 00", {rsp_valid, busy}); end
  endtask

  task automatic test_ripple();
    logic exp_cin[4];
    exp_cin = '{1'b0, 1'b1, 1'b1, 1'b1};
    req0_a = 16'hFFFF; req0_b = 16'h0001; req0_cin = 1'b0; req0_valid = 1'b1;
    run16(1'b0);
    for (int i = 0; i < 4; i++) begin
      vec_cnt++;
      if (obs_cin[i] !== exp_cin[i]) begin err_cnt++; $display("FAIL ripple_cin[%0d]: got %b required %b", i, obs_cin[i], exp_cin[i]); end
    end
    vec_cnt++; if ({rsp_cout, rsp_sum} !== 17'h10000) begin err_cnt++; $display("FAIL ripple_result: got %h required 10000", {rsp_cout, rsp_sum}); end
    consume16();
    req0_a = 16'hFFFF; req0_b = 16'h0000; req0_cin = 1'b1; req0_valid = 1'b1;
    run16(1'b0);
    vec_cnt++; if ({rsp_cout, rsp_sum} !== 17'h10000) begin err_cnt++; $display("FAIL ripple_cin_result: got %h required 10000", {rsp_cout, rsp_sum}); end
    consume16();
  endtask

  task automatic test_fairness();
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    req0_a = 16'h0101; req0_b = 16'h0202; req0_cin = 1'b0;
    req1_a = 16'h1000; req1_b = 16'h2000; req1_cin = 1'b1;
    req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    vec_cnt++; if ({req0_ready, req1_ready} !== 2'b10) begin err_cnt++; $display("FAIL tie_after_reset: got %b required 10", {req0_ready, req1_ready}); end
    run16(1'b0);
    vec_cnt++; if ({rsp_id, rsp_sum} !== {1'b0, 16'h0303}) begin err_cnt++; $display("FAIL tie_first: got id=%b sum=%h required id=0 sum=0303", rsp_id, rsp_sum); end
    consume16();
    #1;
    vec_cnt++; if ({req0_ready, req1_ready} !== 2'b01) begin err_cnt++; $display("FAIL no_bubble_req1: got %b required 01", {req0_ready, req1_ready}); end
    run16(1'b1);
    vec_cnt++; if ({rsp_id, rsp_cout, rsp_sum} !== {2'b10, 16'h3001}) begin err_cnt++; $display("FAIL tie_second: got id=%b cout=%b sum=%h required id=1 cout=0 sum=3001", rsp_id, rsp_cout, rsp_sum); end
    req0_a = 16'h00FF; req0_b = 16'h0001; req0_cin = 1'b0;
    req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    vec_cnt++; if ({req0_ready, req1_ready} !== 2'b00) begin err_cnt++; $display("FAIL done_readys: got %b required 00", {req0_ready, req1_ready}); end
    consume16();
    #1;
    vec_cnt++; if ({req0_ready, req1_ready} !== 2'b10) begin err_cnt++; $display("FAIL rr_back_to_req0: got %b required 10", {req0_ready, req1_ready}); end
    run16(1'b0);
    vec_cnt++; if ({rsp_id, rsp_sum} !== {1'b0, 16'h0100}) begin err_cnt++; $display("FAIL rr_third: got id=%b sum=%h required id=0 sum=0100", rsp_id, rsp_sum); end
    consume16();
    run16(1'b1);
    vec_cnt++; if ({rsp_id, rsp_sum} !== {1'b1, 16'h3001}) begin err_cnt++; $display("FAIL rr_fourth: got id=%b sum=%h required id=1 sum=3001", rsp_id, rsp_sum); end
    consume16();
  endtask

  task automatic test_backpressure();
    req0_a = 16'hABCD; req0_b = 16'h1111; req0_cin = 1'b0; req0_valid = 1'b1;
    run16(1'b0);
    req1_a = 16'h8000; req1_b = 16'h8000; req1_cin = 1'b0; req1_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      vec_cnt++;
      if ({rsp_valid, busy, req0_ready, req1_ready, rsp_id, rsp_cout, rsp_sum} !== {6'b110000, 16'hBCDE}) begin
        err_cnt++;
        $display("FAIL hold_cycle%0d: got v=%b busy=%b rdy=%b%b id=%b cout=%b sum=%h required v=1 busy=1 rdy=00 id=0 cout=0 sum=bcde",
                 i, rsp_valid, busy, req0_ready, req1_ready, rsp_id, rsp_cout, rsp_sum);
      end
    end
    consume16();
    #1;
    vec_cnt++; if ({rsp_valid, req1_ready} !== 2'b01) begin err_cnt++; $display("FAIL release_accept: got v=%b req1_ready=%b required v=0 req1_ready=1", rsp_valid, req1_ready); end
    run16(1'b1);
    vec_cnt++; if ({rsp_id, rsp_cout, rsp_sum} !== {2'b11, 16'h0000}) begin err_cnt++; $display("FAIL pending_result: got id=%b cout=%b sum=%h required id=1 cout=1 sum=0000", rsp_id, rsp_cout, rsp_sum); end
    consume16();
  endtask

  task automatic test_lat3();
    logic [3:0] exp_a[6];
    logic [3:0] got_a[6];
    logic       got_cin[6];
    logic       early;
    exp_a = '{4'hC, 4'hC, 4'hC, 4'h9, 4'h9, 4'h9};
    early = 1'b0;
    s_req0_a = 8'h9C; s_req0_b = 8'h77; s_req0_cin = 1'b1; s_req0_valid = 1'b1;
    #1;
    vec_cnt++; if (s_req0_ready !== 1'b1) begin err_cnt++; $display("FAIL lat3_ready: got %b required 1", s_req0_ready); end
    @(posedge clk);
    @(negedge clk);
    s_req0_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      got_a[i]   = s_add_a;
      got_cin[i] = s_add_cin;
      if (s_rsp_valid !== 1'b0) early = 1'b1;
      @(negedge clk);
    end
    vec_cnt++; if (early !== 1'b0) begin err_cnt++; $display("FAIL lat3_early_valid: got early rsp_valid, required none before 6 cycles"); end
    for (int i = 0; i < 6; i++) begin
      vec_cnt++;
      if ({got_a[i], got_cin[i]} !== {exp_a[i], 1'b1}) begin
        err_cnt++;
        $display("FAIL lat3_drive[%0d]: got a=%h cin=%b required a=%h cin=1", i, got_a[i], got_cin[i], exp_a[i]);
      end
    end
    vec_cnt++;
    if ({s_rsp_valid, s_rsp_cout, s_rsp_id, s_rsp_sum} !== {3'b110, 8'h14}) begin
      err_cnt++;
      $display("FAIL lat3_result: got v=%b cout=%b id=%b sum=%h required v=1 cout=1 id=0 sum=14", s_rsp_valid, s_rsp_cout, s_rsp_id, s_rsp_sum);
    end
    s_rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    s_rsp_ready = 1'b0;
    vec_cnt++; if ({s_rsp_valid, s_busy} !== 2'b00) begin err_cnt++; $display("FAIL lat3_release: got %b required 00", {s_rsp_valid, s_busy}); end
  endtask

  task automatic test_reset_mid();
    logic seen;
    seen = 1'b0;
    req0_a = 16'h1234; req0_b = 16'h1111; req0_cin = 1'b0; req0_valid = 1'b1;
    #1;
    vec_cnt++; if (req0_ready !== 1'b1) begin err_cnt++; $display("FAIL mid_accept: got %b required 1", req0_ready); end
    @(posedge clk);
    @(negedge clk);
    req0_valid = 1'b0;
    @(negedge clk);
    vec_cnt++; if (add_a !== 4'h3) begin err_cnt++; $display("FAIL mid_second_nibble: got %h required 3", add_a); end
    rst = 1'b0;
    #1;
    vec_cnt++;
    if ({rsp_valid, busy, add_a, add_b, add_cin, rsp_sum} !== 27'd0) begin
      err_cnt++;
      $display("FAIL mid_reset_clear: got v=%b busy=%b a=%h b=%h cin=%b sum=%h required all 0", rsp_valid, busy, add_a, add_b, add_cin, rsp_sum);
    end
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (rsp_valid !== 1'b0 || busy !== 1'b0) seen = 1'b1;
    end
    vec_cnt++; if (seen !== 1'b0) begin err_cnt++; $display("FAIL mid_discard: got activity after reset, required none"); end
    req1_a = 16'h0003; req1_b = 16'h0004; req1_cin = 1'b0; req1_valid = 1'b1;
    run16(1'b1);
    vec_cnt++; if ({rsp_id, rsp_cout, rsp_sum} !== {2'b10, 16'h0007}) begin err_cnt++; $display("FAIL mid_resubmit: got id=%b cout=%b sum=%h required id=1 cout=0 sum=0007", rsp_id, rsp_cout, rsp_sum); end
    consume16();
  endtask

  initial begin
    rst = 1'b0;
    req0_valid = 1'b0; req0_a = '0; req0_b = '0; req0_cin = 1'b0;
    req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_cin = 1'b0;
    rsp_ready = 1'b0;
    s_req0_valid = 1'b0; s_req0_a = '0; s_req0_b = '0; s_req0_cin = 1'b0;
    s_req1_valid = 1'b0; s_req1_a = '0; s_req1_b = '0; s_req1_cin = 1'b0;
    s_rsp_ready = 1'b0;
    test_reset();
    test_single();
    test_ripple();
    test_fairness();
    test_backpressure();
    test_lat3();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion by 200000 time units, required earlier finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/nibble_add_sched.md
Name: nibble_add_sched

Overview:
- Shares one 4-bit adder slice (a[3:0], b[3:0], cin in; sum[3:0], cout out) between two requesters.
- Each requester submits a WIDTH-bit add. The block arbitrates round-robin between them.
- It sequences the add LSB-nibble first through the slice, chaining carry between nibbles, and returns the full sum and carry-out tagged with the requester id.
- It sits between the ALU front-end requesters and the shared slice.

Parameters:
- WIDTH, 16, operand width in bits. Must be a multiple of 4 and at least 4. Elaboration error otherwise.
- ADD_LAT, 1, cycles the slice needs from operand drive to a valid sum/cout. Must be at least 1.
- NIB (derived, not overridable), WIDTH/4, number of nibble steps per add.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-low reset.
- req0_valid  in  1  requester 0 has an add pending.
- req0_ready  out  1  requester 0 accepted this cycle.
- req0_a  in  WIDTH  requester 0 operand a.
- req0_b  in  WIDTH  requester 0 operand b.
- req0_cin  in  1  requester 0 carry-in.
- req1_valid / req1_ready / req1_a / req1_b / req1_cin  as requester 0, for requester 1.
- add_a  out  4  nibble of a driven to the slice.
- add_b  out  4  nibble of b driven to the slice.
- add_cin  out  1  carry driven to the slice.
- add_sum  in  4  slice sum.
- add_cout  in  1  slice carry-out.
- rsp_valid  out  1  result available.
- rsp_ready  in  1  consumer takes the result.
- rsp_id  out  1  id of the requester that owns the result.
- rsp_sum  out  WIDTH  full sum.
- rsp_cout  out  1  final carry-out.
- busy  out  1  high in any state except IDLE.

Behaviour:
- Reset (rst=0, async):
  - state=IDLE, rr_ptr=0.
  - All registered outputs are 0: rsp_valid, rsp_id, rsp_sum, rsp_cout, busy.
  - Internal regs cleared: nibble index, wait counter, carry register.
- States: IDLE, RUN, DONE.
- IDLE:
  - Grant goes to the single valid requester. If both are valid, grant goes to rr_ptr.
  - reqX_ready = (state==IDLE) && grant==X. This is combinational, so at most one ready is high in a cycle.
  - On the handshake edge the block latches a, b, cin, and id; sets idx=0, wcnt=0, carry=cin; and moves to RUN.
  - With no valid requester, the block stays in IDLE. Both readys are low.
- RUN:
  - add_a = a[4*idx+3:4*idx], add_b = b[4*idx+3:4*idx], add_cin = carry.
  - These drives are held stable for exactly ADD_LAT cycles per nibble.
  - On the edge ending the ADD_LAT-th cycle of a nibble:
    - sum[4*idx+3:4*idx] <= add_sum; carry <= add_cout.
    - If idx == NIB-1, go to DONE: rsp_cout <= add_cout, rsp_valid <= 1.
    - Otherwise idx++ and wcnt=0.
- add_a, add_b and add_cin are 0 in IDLE and DONE.
- Latency: rsp_valid rises exactly NIB*ADD_LAT cycles after the acceptance edge. WIDTH=16 with ADD_LAT=1 gives 4 cycles.
- DONE:
  - rsp_valid=1. rsp_sum, rsp_cout and rsp_id are held stable until rsp_ready=1 on a clock edge.
  - On that edge: rsp_valid <= 0, rr_ptr <= ~rsp_id, return to IDLE.
  - No new request is accepted before that edge; readys stay low.
  - No bubble cycle is forced: a request can be accepted in the first IDLE cycle after the response handshake.
- Arbitration fairness: after servicing requester X, the other requester wins any tie. A requester held valid is never starved for more than one transaction.
- Requester inputs are sampled only on their handshake edge. Later changes to req*_a/b/cin do not affect an in-flight add.
- Reset asserted mid-RUN or mid-DONE:
  - Immediate return to the reset state; the in-flight result is discarded.
  - No response is produced for it. The requester must resubmit.
- Arithmetic: {rsp_cout, rsp_sum} = a + b + cin, modulo 2^(WIDTH+1). The result is exact, with no saturation.

Test Plan:
- Single add, req0 only: a=0x1234, b=0x0FF1, cin=0, ADD_LAT=1 -> add_a sequence 4,3,2,1 on consecutive cycles. rsp_valid 4 cycles after the handshake with rsp_sum=0x2225, rsp_cout=0, rsp_id=0.
- Full carry ripple: a=0xFFFF, b=0x0001, cin=0 -> add_cin sequence 0,1,1,1. rsp_sum=0x0000, rsp_cout=1. With a=0xFFFF, b=0x0000, cin=1 -> same result.
- Simultaneous requests after reset, both valid and held: req0 is served first (rsp_id=0), then req1 (rsp_id=1). Re-present both -> req0 served next. Readys are never high together.
- Response backpressure: hold rsp_ready=0 for 5 cycles in DONE -> rsp_* stable, busy=1, req0_ready=req1_ready=0. Raising rsp_ready -> rsp_valid low on the next edge, and the pending request is accepted in the following cycle.
- ADD_LAT=3, WIDTH=8: a=0x9C, b=0x77, cin=1 -> each nibble is driven for 3 cycles. rsp_valid 6 cycles after acceptance with rsp_sum=0x14, rsp_cout=1.
- Reset mid-operation: assert rst=0 during the 2nd nibble of RUN -> outputs clear immediately, with no rsp_valid. After release, a fresh req1 add of 0x0003+0x0004 -> rsp_sum=0x0007 with rsp_id=1.
